// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: sequential binary-to-BCD converter plus a
// time-multiplexed seven-segment scan driver with sign and blanking.
//
// Ports:
//   clk      in  1           rising-edge clock
//   rst      in  1           asynchronous reset, active-high
//   value    in  DATA_W      number to display, sampled on accepted load
//   load     in  1           start conversion (accepted only when idle)
//   blank_lz in  1           blank leading zeros, sampled with value
//   busy     out 1           conversion in progress
//   done     out 1           one-cycle pulse when new digits are latched
//   LED_out  out 7           segments {g,f,e,d,c,b,a}, active-low
//   Anode    out NUM_DIGITS  digit enables, active-low one-hot
module ssd_scan_driver #(
    parameter int DATA_W      = 13,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int SIGNED_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            LED_out,
    output logic [NUM_DIGITS-1:0] Anode
);

    // Decimal digits needed for 2**DATA_W-1, i.e. ceil(DATA_W*log10(2)).
    function automatic int f_bcd_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    localparam int BCD_DIGITS = f_bcd_digits(DATA_W);
    localparam int BW    = BCD_DIGITS * 4;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_W-1:0]     r_mag;
    logic [BW-1:0]         r_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg;
    logic                  r_blank;
    logic [BW-1:0]         r_disp;
    logic                  r_neg_q;
    logic                  r_blank_q;
    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_scan;
    logic [6:0]            r_led;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_neg;
    logic [DATA_W-1:0]     w_mag;
    logic [BW-1:0]         w_adj;
    logic [BW+DATA_W-1:0]  w_shift;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_scan_nxt;
    logic [IDX_W-1:0]      w_msd;
    logic [IDX_W-1:0]      w_sign_pos;
    logic [3:0]            w_nib [NUM_DIGITS];
    logic [6:0]            w_seg;

    assign busy    = r_busy;
    assign done    = r_done;
    assign LED_out = r_led;
    assign Anode   = r_an;

    // Magnitude stays DATA_W bits unsigned so the most negative value is exact.
    assign w_neg = (SIGNED_EN != 0) && value[DATA_W-1];
    assign w_mag = w_neg ? (~value + DATA_W'(1)) : value;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5)
                w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
        end
    end

    assign w_shift = {w_adj[BW-2:0], r_mag, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mag     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_blank   <= 1'b0;
            r_disp    <= '0;
            r_neg_q   <= 1'b0;
            r_blank_q <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_mag   <= w_mag;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= w_neg;
                        r_blank <= blank_lz;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_shift[BW+DATA_W-1:DATA_W];
                    r_mag <= w_shift[DATA_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_disp    <= w_shift[BW+DATA_W-1:DATA_W];
                        r_neg_q   <= r_neg;
                        r_blank_q <= r_blank;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        if (g < BCD_DIGITS) begin : g_bcd
            assign w_nib[g] = r_disp[g*4 +: 4];
        end else begin : g_zero
            assign w_nib[g] = 4'd0;
        end
    end

    always_comb begin
        w_msd = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_disp[i*4 +: 4] != 4'd0)
                w_msd = IDX_W'(i);
        end
    end

    assign w_sign_pos = r_blank_q ? (w_msd + IDX_W'(1))
                                  : IDX_W'(NUM_DIGITS - 1);

    assign w_wrap = (r_div == DIV_W'(REFRESH_DIV - 1));

    always_comb begin
        w_scan_nxt = r_scan;
        if (w_wrap)
            w_scan_nxt = (r_scan == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                            : r_scan + IDX_W'(1);
    end

    // Segments are computed for the index being entered so that
    // Anode and LED_out move together on the same edge.
    always_comb begin
        w_seg = f_seg(w_nib[w_scan_nxt]);
        if (r_blank_q && (w_scan_nxt > w_msd))
            w_seg = 7'h7F;
        if (r_neg_q && (w_scan_nxt == w_sign_pos))
            w_seg = 7'h3F;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_scan <= '0;
            r_led  <= 7'h7F;
            r_an   <= '1;
        end else begin
            r_div  <= w_wrap ? '0 : r_div + DIV_W'(1);
            r_scan <= w_scan_nxt;
            r_led  <= w_seg;
            r_an   <= ~(NUM_DIGITS'(1) << w_scan_nxt);
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: a signed instance and an
// unsigned instance share clock and reset.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] value  = '0;
    logic [12:0] value2 = '0;
    logic        load   = 1'b0;
    logic        load2  = 1'b0;
    logic        blank  = 1'b0;
    logic        blank2 = 1'b0;
    logic        busy, done, busy2, done2;
    logic [6:0]  led, led2;
    logic [7:0]  an, an2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .DATA_W(13), .NUM_DIGITS(8), .REFRESH_DIV(4), .SIGNED_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .blank_lz(blank), .busy(busy), .done(done),
        .LED_out(led), .Anode(an)
    );

    ssd_scan_driver #(
        .DATA_W(13), .NUM_DIGITS(8), .REFRESH_DIV(4), .SIGNED_EN(0)
    ) dut2 (
        .clk(clk), .rst(rst), .value(value2), .load(load2),
        .blank_lz(blank2), .busy(busy2), .done(done2),
        .LED_out(led2), .Anode(an2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dig(input bit d2, input int idx,
                           input logic [6:0] exp, input string tag);
        logic [7:0] want;
        int n;
        want = ~(8'd1 << idx);
        n = 0;
        while (((d2 ? an2 : an) !== want) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_anode"}, 32'(d2 ? an2 : an), 32'(want));
        chk(tag, 32'(d2 ? led2 : led), 32'(exp));
    endtask

    task automatic start(input bit d2, input logic [12:0] v,
                         input bit bl);
        @(negedge clk);
        if (d2) begin
            value2 = v; blank2 = bl; load2 = 1'b1;
        end else begin
            value = v; blank = bl; load = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        load2 = 1'b0;
    endtask

    task automatic wait_conv(input bit d2, input int inj,
                             input string tag);
        int n;
        n = 0;
        chk({tag, "_busy_start"}, 32'(d2 ? busy2 : busy), 1);
        while ((d2 ? busy2 : busy) && n < 100) begin
            if (n == inj) begin
                value = 13'd7;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        load = 1'b0;
        chk({tag, "_busy_len"}, 32'(n), 13);
        chk({tag, "_done"}, 32'(d2 ? done2 : done), 1);
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(d2 ? done2 : done), 0);
        chk({tag, "_idle"}, 32'(d2 ? busy2 : busy), 0);
    endtask

    initial begin
        int n;
        int dn;
        logic [7:0] want;

        // Reset state.
        @(negedge clk);
        chk("rst_anode", 32'(an), 32'hFF);
        chk("rst_led", 32'(led), 32'h7F);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_anode", 32'(an), 32'hFE);
        chk("first_led", 32'(led), 32'h40);

        // Scan rotation: each later digit stays lit 4 clocks.
        want = 8'hFD;
        n = 0;
        while (an !== want && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("scan_d1", 32'(an), 32'(want));
        for (int k = 2; k <= 8; k++) begin
            want = ~(8'd1 << (k % 8));
            n = 0;
            while (an !== want && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("scan_d%0d", k % 8), 32'(an), 32'(want));
            chk($sformatf("scan_per%0d", k % 8), 32'(n), 4);
        end

        // 1234 with leading-zero blanking.
        start(1'b0, 13'd1234, 1'b1);
        wait_conv(1'b0, -1, "c1234");
        chk_dig(1'b0, 0, 7'h19, "c1234_d0");
        chk_dig(1'b0, 1, 7'h30, "c1234_d1");
        chk_dig(1'b0, 2, 7'h24, "c1234_d2");
        chk_dig(1'b0, 3, 7'h79, "c1234_d3");
        chk_dig(1'b0, 4, 7'h7F, "c1234_d4");
        chk_dig(1'b0, 7, 7'h7F, "c1234_d7");

        // Most negative value.
        start(1'b0, 13'h1000, 1'b1);
        wait_conv(1'b0, -1, "cneg");
        chk_dig(1'b0, 0, 7'h02, "cneg_d0");
        chk_dig(1'b0, 1, 7'h10, "cneg_d1");
        chk_dig(1'b0, 2, 7'h40, "cneg_d2");
        chk_dig(1'b0, 3, 7'h19, "cneg_d3");
        chk_dig(1'b0, 4, 7'h3F, "cneg_d4");
        chk_dig(1'b0, 5, 7'h7F, "cneg_d5");

        // Load while busy is ignored.
        start(1'b0, 13'd1234, 1'b1);
        wait_conv(1'b0, 5, "cign");
        chk_dig(1'b0, 0, 7'h19, "cign_d0");
        chk_dig(1'b0, 3, 7'h79, "cign_d3");
        chk_dig(1'b0, 4, 7'h7F, "cign_d4");

        // Reset mid-conversion.
        start(1'b0, 13'h1000, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_anode", 32'(an), 32'hFF);
        chk("mrst_led", 32'(led), 32'h7F);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("mrst_nodone", 32'(dn), 0);
        chk_dig(1'b0, 0, 7'h40, "mrst_d0");
        chk_dig(1'b0, 3, 7'h40, "mrst_d3");
        chk_dig(1'b0, 4, 7'h40, "mrst_d4");

        // Unsigned instance, no blanking.
        start(1'b1, 13'd8191, 1'b0);
        wait_conv(1'b1, -1, "cuns");
        chk_dig(1'b1, 0, 7'h79, "cuns_d0");
        chk_dig(1'b1, 1, 7'h10, "cuns_d1");
        chk_dig(1'b1, 2, 7'h79, "cuns_d2");
        chk_dig(1'b1, 3, 7'h00, "cuns_d3");
        chk_dig(1'b1, 4, 7'h40, "cuns_d4");
        chk_dig(1'b1, 7, 7'h40, "cuns_d7");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
